// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states, address width, ACK and R/W encodings.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic ACK        = 1'b0;
    localparam logic NACK       = 1'b1;
    localparam logic RW_WRITE   = 1'b0;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
// The sync registers reset high so that the bus looks idle out of reset.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;
    logic       scl;

    // two-stage synchronizers plus one register of the previous synced sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_i};
            sda_ff <= {sda_ff[0], sda_i};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end

    assign scl      = scl_ff[1];
    assign sda      = sda_ff[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high in both samples, so a simultaneous SCL/SDA change is data
    assign start    = scl_q & scl & sda_q & ~sda;
    assign stop     = scl_q & scl & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write bytes out on rx_data/rx_valid, read bytes
// fetched through tx_req/tx_data, SDA driven open-drain via sda_oe.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_e state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg, shreg_n, byte_in, rx_data_n;
    logic       rw, rw_n, ack_on, ack_on_n, ld, ld_n;
    logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n;

    // state and datapath registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            rw       <= RW_WRITE;
            ack_on   <= 1'b0;
            ld       <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            rw       <= rw_n;
            ack_on   <= ack_on_n;
            ld       <= ld_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
        end
    end

    // next-state and output logic driven by synced bus events
    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        rw_n       = rw;
        ack_on_n   = ack_on;
        ld_n       = ld;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;
        byte_in    = {shreg[6:0], sda};
        if (stop) begin
            state_n  = S_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            ack_on_n = 1'b0;
        end else if (start) begin
            state_n  = S_ADDR;
            bitcnt_n = '0;
            sda_oe_n = 1'b0;
            ack_on_n = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    shreg_n  = byte_in;
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        if (byte_in[7:1] == ADDR) begin
                            state_n = S_ADDR_ACK;
                            busy_n  = 1'b1;
                            rw_n    = byte_in[0];
                        end else begin
                            state_n = S_WAIT_STOP;
                            busy_n  = 1'b0;
                        end
                    end
                end
                // ACK window runs from the first falling edge to the next one
                S_ADDR_ACK, S_RX_ACK: begin
                    if (scl_rise && state == S_ADDR_ACK && rw == RW_READ)
                        tx_req_n = 1'b1;
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_n = 1'b1;
                            sda_oe_n = 1'b1;
                        end else begin
                            ack_on_n = 1'b0;
                            sda_oe_n = 1'b0;
                            bitcnt_n = '0;
                            if (state == S_ADDR_ACK && rw == RW_READ) begin
                                // the falling edge ending the ACK also puts out bit 7
                                state_n  = S_TX_BYTE;
                                shreg_n  = tx_data;
                                sda_oe_n = ~tx_data[7];
                            end else begin
                                state_n = S_RX_BYTE;
                            end
                        end
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    shreg_n  = byte_in;
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        rx_data_n  = byte_in;
                        rx_valid_n = 1'b1;
                        state_n    = S_RX_ACK;
                    end
                end
                S_TX_BYTE: if (scl_fall) begin
                    if (ld) begin
                        ld_n     = 1'b0;
                        shreg_n  = tx_data;
                        sda_oe_n = ~tx_data[7];
                        bitcnt_n = '0;
                    end else if (bitcnt == 3'd7) begin
                        sda_oe_n = 1'b0;
                        state_n  = S_TX_ACK;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end
                S_TX_ACK: if (scl_rise) begin
                    if (sda == ACK) begin
                        tx_req_n = 1'b1;
                        ld_n     = 1'b1;
                        state_n  = S_TX_BYTE;
                    end else begin
                        sda_oe_n = 1'b0;
                        busy_n   = 1'b0;
                        state_n  = S_WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench acting as I2C master; a transaction-level model predicts ACKs, read
// bits, busy, rx bytes and tx_req counts, and a monitor compares every cycle.
module tb_i2c_slave_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_i, sda_i, sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    i2c_slave_responder dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int q = 4;
    int txreq_n = 0;
    int rise8_cyc = 0;
    logic exp_oe = 1'b0, chk_oe = 1'b0, exp_busy = 1'b0, chk_busy = 1'b0;
    logic busy_m = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] dbuf[4];
    logic [7:0] rd_got[4];

    task automatic check_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_v(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // per-cycle monitor: sda_oe/busy windows, rx byte order and latency, pulse widths
    initial begin
        logic prv_rxv, prv_txr;
        logic [7:0] e;
        prv_rxv = 1'b0;
        prv_txr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (chk_oe)   check_b("sda_oe", sda_oe, exp_oe);
                if (chk_busy) check_b("busy", busy, exp_busy);
                if (rx_valid) begin
                    check_b("rx_valid_width", prv_rxv, 1'b0);
                    if (rxq.size() == 0) begin
                        check_b("rx_valid_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = rxq.pop_front();
                        check_v("rx_data", int'(rx_data), int'(e));
                        check_v("rx_valid_latency", cyc - rise8_cyc, 3);
                    end
                end
                if (tx_req) begin
                    check_b("tx_req_width", prv_txr, 1'b0);
                    txreq_n++;
                    if (txq.size() > 0) tx_data = txq.pop_front();
                end
            end
            prv_rxv = rx_valid;
            prv_txr = tx_req;
        end
    end

    // one SCL clock: fall, set data, settle, rise (sample bus), high phase
    task automatic bit_slot(input logic b, input logic e_oe, input logic e_busy,
                            input bit is8, output logic s);
        m_scl = 1'b0; chk_oe = 1'b0; chk_busy = 1'b0;
        @(negedge clk); m_sda = b;
        repeat (2) @(negedge clk);
        exp_oe = e_oe; exp_busy = e_busy; chk_oe = 1'b1; chk_busy = 1'b1;
        repeat (2*q-3) @(negedge clk);
        chk_busy = 1'b0;
        s = sda_i;
        m_scl = 1'b1;
        if (is8) rise8_cyc = cyc;
        repeat (2*q) @(negedge clk);
    endtask

    task automatic do_start();
        m_scl = 1'b0; chk_oe = 1'b0; chk_busy = 1'b0;
        @(negedge clk); m_sda = 1'b1;
        repeat (2*q-1) @(negedge clk); m_scl = 1'b1;
        repeat (q) @(negedge clk); m_sda = 1'b0;
        repeat (q) @(negedge clk);
    endtask

    task automatic do_stop();
        m_scl = 1'b0; chk_oe = 1'b0; chk_busy = 1'b0;
        @(negedge clk); m_sda = 1'b0;
        repeat (2*q-1) @(negedge clk); m_scl = 1'b1;
        repeat (q) @(negedge clk); m_sda = 1'b1;
        repeat (2*q) @(negedge clk);
        busy_m = 1'b0;
        check_b("stop_oe", sda_oe, 1'b0);
        check_b("stop_busy", busy, 1'b0);
    endtask

    // master writes a byte; ack_exp is whether the target should pull the ACK slot
    task automatic send_byte(input logic [7:0] d, input logic ack_exp, input logic b_lo,
                             input logic b_ack, output logic s);
        for (int i = 7; i >= 0; i--) bit_slot(d[i], 1'b0, b_lo, i == 0, s);
        bit_slot(1'b1, ack_exp, b_ack, 1'b0, s);
    endtask

    // master reads a byte; drive says whether the target should be putting bits out
    task automatic recv_byte(input logic [7:0] d, input logic drive, input logic last,
                             output logic [7:0] got);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, drive & ~d[i], busy_m, 1'b0, s);
            got[i] = s;
        end
        bit_slot(last, 1'b0, busy_m, 1'b0, s);
    endtask

    // one addressed transaction from START; leaves SCL high after the last ACK slot
    task automatic xfer(input logic [6:0] a7, input logic rw, input int n, input bit stop_after);
        logic hit, s;
        logic [7:0] got;
        hit = (a7 == 7'h50);
        if (hit && rw) for (int i = 0; i < n; i++) txq.push_back(dbuf[i]);
        do_start();
        send_byte({a7, rw}, hit, busy_m, hit, s);
        check_b("addr_ack", ~s, hit);
        busy_m = hit;
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                if (hit) rxq.push_back(dbuf[i]);
                send_byte(dbuf[i], hit, busy_m, busy_m, s);
                check_b("data_ack", ~s, hit);
            end else begin
                recv_byte(dbuf[i], hit, i == n-1, got);
                check_v("rd_byte", int'(got), hit ? int'(dbuf[i]) : 255);
                rd_got[i] = got;
            end
        end
        if (rw) busy_m = 1'b0;
        check_v("tx_req_count", txreq_n, (hit && rw) ? n : 0);
        check_v("rx_pending", rxq.size(), 0);
        check_v("tx_pending", txq.size(), 0);
        txreq_n = 0;
        if (stop_after) do_stop();
    endtask

    task automatic reset_mid_tx();
        logic s;
        logic [7:0] d;
        d = 8'h96;
        txq.push_back(d);
        do_start();
        send_byte(8'hA1, 1'b1, busy_m, 1'b1, s);
        check_b("rst_addr_ack", ~s, 1'b1);
        busy_m = 1'b1;
        for (int i = 7; i >= 4; i--) bit_slot(1'b1, ~d[i], 1'b1, 1'b0, s);
        m_scl = 1'b0; chk_oe = 1'b0; chk_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_b("tx_bit3_driven", sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        check_b("rst_async_oe", sda_oe, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        busy_m = 1'b0;
        txreq_n = 0;
        txq.delete();
        repeat (2*q) @(negedge clk);
        m_scl = 1'b1;
        repeat (2*q) @(negedge clk);
        for (int i = 0; i < 12; i++) bit_slot(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, s);
        check_v("rst_idle_tx_req", txreq_n, 0);
        check_v("rst_rx_data", int'(rx_data), 0);
        do_stop();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_b("reset_sda_oe", sda_oe, 1'b0);
        check_v("reset_rx_data", int'(rx_data), 0);
        check_b("reset_rx_valid", rx_valid, 1'b0);
        check_b("reset_tx_req", tx_req, 1'b0);
        check_b("reset_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        for (int pass = 0; pass < 2; pass++) begin
            q = (pass == 0) ? 4 : 2;
            dbuf[0] = 8'h3C;
            xfer(7'h50, 1'b0, 1, 1'b1);
            check_v("write_lit", int'(rx_data), 8'h3C);
            dbuf[0] = 8'h96; dbuf[1] = 8'h5A;
            xfer(7'h50, 1'b1, 2, 1'b1);
            check_v("read_lit0", int'(rd_got[0]), 8'h96);
            check_v("read_lit1", int'(rd_got[1]), 8'h5A);
            dbuf[0] = 8'h77;
            xfer(7'h51, 1'b0, 1, 1'b1);
            check_v("mismatch_keeps_rx", int'(rx_data), 8'h3C);
            dbuf[0] = 8'h11;
            xfer(7'h50, 1'b0, 1, 1'b0);
            dbuf[0] = 8'hC3;
            xfer(7'h50, 1'b1, 1, 1'b1);
            check_v("rstart_rx_lit", int'(rx_data), 8'h11);
            check_v("rstart_rd_lit", int'(rd_got[0]), 8'hC3);
            reset_mid_tx();
            dbuf[0] = 8'hE5;
            xfer(7'h50, 1'b0, 1, 1'b1);
            check_v("post_reset_rx", int'(rx_data), 8'hE5);
        end

        for (int t = 0; t < 24; t++) begin
            logic [6:0] a7;
            logic rw;
            int n;
            bit st;
            q  = $urandom_range(2, 4);
            a7 = 7'h50;
            if ($urandom_range(0, 3) == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h50) a7 = 7'h51;
            end
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom_range(0, 255));
            st = (t == 23) || ($urandom_range(0, 3) != 0);
            xfer(a7, rw, n, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
